ps2_kbd_ctrl: RTL
=================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter TMO_CYC, default 50000, meaning clk cycles a pending prefix (E0/F0) may wait for the next byte before it is discarded.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port kb_data  input  8  scan byte from receiver FIFO head.
REQ-005 SHALL have port kb_ready  input  1  receiver FIFO non-empty.
REQ-006 SHALL have port kb_overflow  input  1  receiver FIFO overflow flag.
REQ-007 SHALL have port kb_rd  output  1  one-cycle pop request to the receiver.
REQ-008 SHALL have port key_valid  output  1  one-cycle key event strobe.
REQ-009 SHALL have port key_code  output  8  scan code of the event (excluding prefixes).
REQ-010 SHALL have port key_ext  output  1  event carried an E0 prefix.
REQ-011 SHALL have port key_release  output  1  event carried an F0 prefix (break).
REQ-012 SHALL have port key_held  output  1  a key is currently held.
REQ-013 SHALL have port press_cnt  output  8  count of distinct key presses, wraps 255->0.
REQ-014 SHALL have port err  output  1  sticky: overflow seen or pause sequence malformed.

Function
REQ-015 SHALL implement states IDLE, POP, DECODE, SKIP.
REQ-016 IDLE: when kb_ready=1, SHALL assert kb_rd for exactly one cycle and enter POP; otherwise stay.
REQ-017 POP: SHALL register kb_data (valid one cycle after kb_rd) into an internal byte register, kb_rd=0, enter DECODE.
REQ-018 DECODE, byte E0: SHALL set ext flag, no event, return IDLE.
REQ-019 DECODE, byte F0: SHALL set brk flag, no event, return IDLE.
REQ-020 DECODE, byte E1: SHALL load skip counter with 7, clear ext/brk, enter SKIP.
REQ-021 DECODE, byte AA, FA, FE or 00: SHALL discard without event, flags cleared, return IDLE.
REQ-022 DECODE, any other byte: SHALL pulse key_valid one cycle with key_code=byte, key_ext=ext, key_release=brk, clear ext/brk, return IDLE; key_code/key_ext/key_release hold until next event.
REQ-023 Make event (brk=0) whose {ext,code} differs from held register or key_held=0: SHALL increment press_cnt by 1, load held register, set key_held=1.
REQ-024 Make event equal to held register (typematic repeat): SHALL emit key_valid but SHALL NOT change press_cnt.
REQ-025 Break event matching held register: SHALL clear key_held; non-matching break leaves key_held unchanged.
REQ-026 SKIP: SHALL pop bytes via IDLE-style handshake (kb_rd then capture), decrementing counter per byte; at 0 SHALL emit key_valid with key_code=E1, key_ext=0, key_release=0, no press_cnt change, return IDLE.
REQ-027 SKIP: a byte of F0-free sequence mismatch is not checked except: byte E1 inside SKIP SHALL set err and restart counter at 7.
REQ-028 Prefix timeout: SHALL count clk cycles while ext or brk is set in IDLE with kb_ready=0; at TMO_CYC SHALL clear ext and brk and reset counter; counter resets on every pop.
REQ-029 kb_overflow=1 in any cycle SHALL set err (sticky until reset), clear ext/brk, and abort SKIP to IDLE without event.
REQ-030 kb_rd SHALL never be asserted in two consecutive cycles, and never when kb_ready=0.
REQ-031 Maximum throughput SHALL be one byte per 3 cycles.

Reset
REQ-032 clrn=0 SHALL immediately force state IDLE, kb_rd=0, key_valid=0, key_code=00, key_ext=0, key_release=0, key_held=0, press_cnt=0, err=0, flags, timeout and skip counters 0, independent of clk.
REQ-033 Reset asserted mid-sequence SHALL discard any partial prefix or SKIP progress; first byte after release is decoded as a fresh sequence.

Verification
REQ-034 Bytes 1C,F0,1C -> two key_valid: (1C,ext0,rel0) then (1C,ext0,rel1); press_cnt=1; key_held 1 then 0.
REQ-035 Bytes 1C,1C,1C,F0,1C -> four key_valid, press_cnt=1 (repeat not counted).
REQ-036 Bytes E0,75,E0,F0,75 -> events (75,ext1,rel0),(75,ext1,rel1); press_cnt=1; bytes 1C vs E0,1C treated as distinct keys (press_cnt increments).
REQ-037 Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one key_valid with code E1, press_cnt unchanged, err=0.
REQ-038 Byte F0 then kb_ready=0 for TMO_CYC cycles, then 1C -> event (1C,rel0), press_cnt+1.
REQ-039 kb_overflow pulse during SKIP -> err=1, no event, next byte 1C decoded as make; clrn low mid-E0 prefix -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code decoder: pops bytes from a receiver FIFO, folds
// E0/F0 prefixes into key events, swallows the Pause (E1) sequence as a
// single event, and tracks the currently held key and a press counter.
module ps2_kbd_ctrl #(
  parameter int TMO_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_held,
  output logic [7:0] press_cnt,
  output logic       err
);

  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, POP, DECODE, SKIP} state_t;

  state_t          state;
  logic [7:0]      byte_reg;
  logic            ext_flag;
  logic            brk_flag;
  logic [2:0]      skip_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [8:0]      held_key;

  // Main controller: byte handshake, prefix decoding, pause skipping,
  // held-key tracking, prefix timeout and overflow handling.
  // Within the pause sequence the only legal E1 is the one arriving while
  // five bytes remain (third byte after the leading E1); any other E1 means
  // the sequence was broken and it is restarted with err raised.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      kb_rd       <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      press_cnt   <= 8'h00;
      err         <= 1'b0;
      byte_reg    <= 8'h00;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      skip_cnt    <= 3'd0;
      tmo_cnt     <= '0;
      held_key    <= 9'h000;
    end else begin
      kb_rd     <= 1'b0;
      key_valid <= 1'b0;

      if (kb_overflow && (state == SKIP || skip_cnt != 3'd0)) begin
        state    <= IDLE;
        skip_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (kb_ready) begin
              kb_rd <= 1'b1;
              state <= POP;
            end
          end

          POP: begin
            byte_reg <= kb_data;
            state    <= DECODE;
          end

          DECODE: begin
            if (skip_cnt != 3'd0) begin
              if (byte_reg == 8'hE1 && skip_cnt != 3'd5) begin
                err      <= 1'b1;
                skip_cnt <= 3'd7;
                state    <= SKIP;
              end else if (skip_cnt == 3'd1) begin
                skip_cnt    <= 3'd0;
                key_valid   <= 1'b1;
                key_code    <= 8'hE1;
                key_ext     <= 1'b0;
                key_release <= 1'b0;
                state       <= IDLE;
              end else begin
                skip_cnt <= skip_cnt - 3'd1;
                state    <= SKIP;
              end
            end else begin
              state <= IDLE;
              case (byte_reg)
                8'hE0: ext_flag <= 1'b1;
                8'hF0: brk_flag <= 1'b1;
                8'hE1: begin
                  skip_cnt <= 3'd7;
                  ext_flag <= 1'b0;
                  brk_flag <= 1'b0;
                  state    <= SKIP;
                end
                8'hAA, 8'hFA, 8'hFE, 8'h00: begin
                  ext_flag <= 1'b0;
                  brk_flag <= 1'b0;
                end
                default: begin
                  key_valid   <= 1'b1;
                  key_code    <= byte_reg;
                  key_ext     <= ext_flag;
                  key_release <= brk_flag;
                  ext_flag    <= 1'b0;
                  brk_flag    <= 1'b0;
                  if (!brk_flag) begin
                    if (!key_held || held_key != {ext_flag, byte_reg}) begin
                      press_cnt <= press_cnt + 8'd1;
                      held_key  <= {ext_flag, byte_reg};
                      key_held  <= 1'b1;
                    end
                  end else if (key_held && held_key == {ext_flag, byte_reg}) begin
                    key_held <= 1'b0;
                  end
                end
              endcase
            end
          end

          SKIP: begin
            if (kb_ready) begin
              kb_rd <= 1'b1;
              state <= POP;
            end
          end

          default: state <= IDLE;
        endcase
      end

      if (state == IDLE && (ext_flag || brk_flag) && !kb_ready) begin
        if (tmo_cnt == TW'(TMO_CYC - 1)) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else if (state == POP) begin
        tmo_cnt <= '0;
      end

      if (kb_overflow) begin
        err      <= 1'b1;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

endmodule
